frame_check: RTL

//  Receive-side counterpart of the SFP test-frame generator. It sits on the GTP RX user

---
 rtl/frame_check.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/frame_check.sv
// frame_check: aligns the GTP RX word stream to the K28.5 comma, checks the 4-word test frame, tracks lock and counts.
// Latency 2 rx_clk from PAT2 word to frame_ok/frame_bad; no backpressure, one word is consumed every rx_clk.
module frame_check #(
  parameter logic [15:0] COMMA       = 16'hBCBC,
  parameter logic [15:0] PAT0        = 16'h5854,
  parameter logic [15:0] PAT1        = 16'h4034,
  parameter logic [15:0] PAT2        = 16'h23A7,
  parameter int          LOCK_FRAMES = 4,
  parameter int          LOSS_FRAMES = 2,
  parameter int          CNT_W       = 16
) (
  input  logic             rx_clk,
  input  logic             aresetn,
  input  logic [15:0]      rx_data,
  input  logic [1:0]       rx_is_k,
  input  logic [1:0]       rx_disperr,
  input  logic [1:0]       rx_notintable,
  input  logic             rx_ready,
  input  logic             clear,
  output logic             locked,
  output logic             byte_swap,
  output logic             frame_ok,
  output logic             frame_bad,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef struct packed {
    logic [15:0] dat;
    logic [1:0]  k;
    logic [1:0]  err;
  } word_t;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(LOSS_FRAMES + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_FRAMES - 1);

  logic [7:0]    prev_hi;
  logic          prev_k_hi;
  logic          prev_err_hi;
  logic          swap_q;
  word_t         al_q;
  logic          al_vld;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic          frame_err_q, frame_err_d;
  logic          ok_d, bad_pulse_d;

  logic [1:0]    raw_err;
  logic          norm_hit, swap_hit, sel_swap;
  word_t         al_d;
  logic [15:0]   exp_dat;
  logic [1:0]    exp_k;
  logic          al_comma, word_err, checking, resync, err_inc;

  assign raw_err  = rx_disperr | rx_notintable;
  assign norm_hit = (rx_data == COMMA) && (rx_is_k == 2'b11);
  assign swap_hit = (rx_data[7:0] == COMMA[7:0]) && rx_is_k[0] &&
                    (prev_hi == COMMA[15:8]) && prev_k_hi;

  // Alignment is only re-chosen while hunting; otherwise the latched mode is reused.
  always_comb begin
    sel_swap = swap_q;
    if (state_q == HUNT) begin
      if (norm_hit)      sel_swap = 1'b0;
      else if (swap_hit) sel_swap = 1'b1;
    end
    al_d = '{dat: rx_data, k: rx_is_k, err: raw_err};
    if (sel_swap)
      al_d = '{dat: {rx_data[7:0], prev_hi},
               k:   {rx_is_k[0], prev_k_hi},
               err: {raw_err[0], prev_err_hi}};
  end

  always_comb begin
    exp_dat = COMMA;
    exp_k   = 2'b11;
    case (idx_q)
      2'd1:    begin exp_dat = PAT0; exp_k = 2'b00; end
      2'd2:    begin exp_dat = PAT1; exp_k = 2'b00; end
      2'd3:    begin exp_dat = PAT2; exp_k = 2'b00; end
      default: begin exp_dat = COMMA; exp_k = 2'b11; end
    endcase
  end

  assign al_comma = (al_q.dat == COMMA) && (al_q.k == 2'b11);
  assign word_err = (al_q.dat != exp_dat) || (al_q.k != exp_k) || (|al_q.err);
  assign checking = al_vld && (state_q != HUNT);
  assign resync   = checking && al_comma && (idx_q != 2'd0);
  assign err_inc  = checking && (state_q == LOCKED) && word_err;

  // The lock FSM reacts to the registered frame pulses, so state moves one cycle after a pulse.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    good_d      = good_q;
    bad_d       = bad_q;
    frame_err_d = frame_err_q;
    ok_d        = 1'b0;
    bad_pulse_d = 1'b0;

    if (checking) begin
      if (resync) begin
        idx_d       = 2'd1;
        frame_err_d = 1'b1;
      end else if (idx_q == 2'd3) begin
        idx_d       = 2'd0;
        frame_err_d = 1'b0;
        ok_d        = !(frame_err_q || word_err);
        bad_pulse_d = frame_err_q || word_err;
      end else begin
        idx_d       = idx_q + 2'd1;
        frame_err_d = frame_err_q || word_err;
      end
    end

    case (state_q)
      HUNT: begin
        if (al_vld && al_comma) begin
          state_d     = SYNC;
          idx_d       = 2'd1;
          good_d      = '0;
          bad_d       = '0;
          frame_err_d = 1'b0;
        end
      end
      SYNC: begin
        if (frame_ok) begin
          if (good_q == GOOD_LAST) begin
            state_d = LOCKED;
            bad_d   = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end else if (frame_bad) begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (frame_bad) begin
          if (bad_q == BAD_LAST) state_d = HUNT;
          else                   bad_d   = bad_q + BW'(1);
        end else if (frame_ok) begin
          bad_d = '0;
        end
      end
      default: state_d = HUNT;
    endcase

    if (state_d == HUNT && state_q != HUNT) begin
      idx_d       = 2'd0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge rx_clk or negedge aresetn) begin
    if (!aresetn) begin
      prev_hi     <= '0;
      prev_k_hi   <= 1'b0;
      prev_err_hi <= 1'b0;
      swap_q      <= 1'b0;
      al_q        <= '0;
      al_vld      <= 1'b0;
      state_q     <= HUNT;
      idx_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      frame_err_q <= 1'b0;
      frame_ok    <= 1'b0;
      frame_bad   <= 1'b0;
    end else if (!rx_ready) begin
      prev_hi     <= '0;
      prev_k_hi   <= 1'b0;
      prev_err_hi <= 1'b0;
      swap_q      <= 1'b0;
      al_q        <= '0;
      al_vld      <= 1'b0;
      state_q     <= HUNT;
      idx_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      frame_err_q <= 1'b0;
      frame_ok    <= 1'b0;
      frame_bad   <= 1'b0;
    end else begin
      prev_hi     <= rx_data[15:8];
      prev_k_hi   <= rx_is_k[1];
      prev_err_hi <= raw_err[1];
      swap_q      <= sel_swap;
      al_q        <= al_d;
      al_vld      <= 1'b1;
      state_q     <= state_d;
      idx_q       <= idx_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      frame_err_q <= frame_err_d;
      frame_ok    <= ok_d;
      frame_bad   <= bad_pulse_d;
    end
  end

  // Counters survive rx_ready dropping so a link flap does not erase statistics.
  always_ff @(posedge rx_clk or negedge aresetn) begin
    if (!aresetn) begin
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else if (clear) begin
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else if (rx_ready) begin
      if (frame_ok)
        frame_cnt <= frame_cnt + CNT_W'(1);
      if (err_inc && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign locked    = (state_q == LOCKED);
  assign byte_swap = swap_q;

endmodule
